// File: rtl/vector_dispatch_engine.sv
// Vector dispatch engine: reads a {size, ptr} descriptor from RAM, applies a scalar op to each element in place, raises done/irq.
// Latency: 2*(MEM_LATENCY+1) header cycles + (MEM_LATENCY+2) per element + 1 DONE cycle; control reads return 1 cycle after read_control.
// Backpressure: none; one RAM access per cycle, a start write while busy is dropped, BASE/SCALAR/op are latched at start.
// Ports: control slave (address_control/data_in_control/write_control/read_control/data_out_control),
//        RAM master (mem_address/mem_data_out/mem_data_in/mem_wren), level interrupt_start.
module vector_dispatch_engine #(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_SIZE    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset_n,
    input  logic [1:0]            address_control,
    input  logic [WIDTH-1:0]      data_in_control,
    input  logic                  write_control,
    input  logic                  read_control,
    output logic [WIDTH-1:0]      data_out_control,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]      mem_data_out,
    input  logic [WIDTH-1:0]      mem_data_in,
    output logic                  mem_wren,
    output logic                  interrupt_start
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_SIZE, S_HDR_ADDR, S_RD, S_WAIT, S_WR, S_DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  irq_en_q, irq_en_d;
    logic [1:0]            op_q, op_d;
    logic [1:0]            run_op_q, run_op_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WIDTH-1:0]      base_q, base_d;
    logic [WIDTH-1:0]      scalar_q, scalar_d;
    logic [ADDR_WIDTH-1:0] run_base_q, run_base_d;
    logic [WIDTH-1:0]      run_scalar_q, run_scalar_d;
    logic [WIDTH-1:0]      size_q, size_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [WIDTH-1:0]      mem_data_out_q, mem_data_out_d;
    logic                  mem_wren_q, mem_wren_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0]      alu_res;
    logic                  busy;

    assign busy             = (state_q != S_IDLE);
    assign data_out_control = rdata_q;
    assign mem_address      = mem_address_q;
    assign mem_data_out     = mem_data_out_q;
    assign mem_wren         = mem_wren_q;
    assign interrupt_start  = done_q & irq_en_q;

    // Element operation, applied to the word arriving on the last WAIT cycle.
    always_comb begin
        alu_res = mem_data_in + run_scalar_q;
        case (run_op_q)
            2'd0: alu_res = mem_data_in + run_scalar_q;
            2'd1: alu_res = mem_data_in * run_scalar_q;
            2'd2: alu_res = mem_data_in ^ run_scalar_q;
            2'd3: alu_res = (mem_data_in > run_scalar_q) ? mem_data_in : run_scalar_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        irq_en_d       = irq_en_q;
        op_d           = op_q;
        run_op_d       = run_op_q;
        done_d         = done_q;
        error_d        = error_q;
        base_d         = base_q;
        scalar_d       = scalar_q;
        run_base_d     = run_base_q;
        run_scalar_d   = run_scalar_q;
        size_d         = size_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mem_wren_d     = 1'b0;
        rdata_d        = rdata_q;

        if (read_control) begin
            rdata_d = '0;
            case (address_control)
                2'd0: rdata_d[3:1] = {op_q, irq_en_q};
                2'd1: rdata_d[2:0] = {error_q, done_q, busy};
                2'd2: rdata_d      = base_q;
                2'd3: rdata_d      = scalar_q;
            endcase
        end

        if (write_control) begin
            case (address_control)
                2'd0: begin
                    irq_en_d = data_in_control[1];
                    op_d     = data_in_control[3:2];
                    if (data_in_control[0] && (state_q == S_IDLE)) begin
                        done_d        = 1'b0;
                        error_d       = 1'b0;
                        run_op_d      = data_in_control[3:2];
                        run_base_d    = base_q[ADDR_WIDTH-1:0];
                        run_scalar_d  = scalar_q;
                        mem_address_d = base_q[ADDR_WIDTH-1:0];
                        cnt_d         = '0;
                        state_d       = S_HDR_SIZE;
                    end
                end
                2'd1: begin
                    if (data_in_control[1]) done_d  = 1'b0;
                    if (data_in_control[2]) error_d = 1'b0;
                end
                2'd2: base_d   = data_in_control;
                2'd3: scalar_d = data_in_control;
            endcase
        end

        // FSM follows the register writes so that the DONE set beats a W1C of done.
        case (state_q)
            S_HDR_SIZE: begin
                if (cnt_q == LAT) begin
                    size_d        = mem_data_in;
                    cnt_d         = '0;
                    mem_address_d = run_base_q + ADDR_WIDTH'(1);
                    state_d       = S_HDR_ADDR;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HDR_ADDR: begin
                if (cnt_q == LAT) begin
                    ptr_d = mem_data_in[ADDR_WIDTH-1:0];
                    idx_d = '0;
                    cnt_d = '0;
                    if (size_q == '0) begin
                        state_d = S_DONE;
                    end else if (size_q > WIDTH'(MAX_SIZE)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mem_address_d = mem_data_in[ADDR_WIDTH-1:0];
                        state_d       = S_RD;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RD: begin
                cnt_d   = 3'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    mem_data_out_d = alu_res;
                    mem_wren_d     = 1'b1;
                    state_d        = S_WR;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WR: begin
                idx_d = idx_q + WIDTH'(1);
                if (idx_q + WIDTH'(1) == size_q) begin
                    state_d = S_DONE;
                end else begin
                    mem_address_d = ptr_q + idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                    state_d       = S_RD;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            irq_en_q       <= 1'b0;
            op_q           <= '0;
            run_op_q       <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            base_q         <= '0;
            scalar_q       <= '0;
            run_base_q     <= '0;
            run_scalar_q   <= '0;
            size_q         <= '0;
            ptr_q          <= '0;
            idx_q          <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mem_wren_q     <= 1'b0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            irq_en_q       <= irq_en_d;
            op_q           <= op_d;
            run_op_q       <= run_op_d;
            done_q         <= done_d;
            error_q        <= error_d;
            base_q         <= base_d;
            scalar_q       <= scalar_d;
            run_base_q     <= run_base_d;
            run_scalar_q   <= run_scalar_d;
            size_q         <= size_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_wren_q     <= mem_wren_d;
            rdata_q        <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vector_dispatch_engine.sv
// Bench for vector_dispatch_engine: a MEM_LATENCY=1 and a MEM_LATENCY=3 instance share one control bus,
// each with its own RAM; a descriptor-level reference RAM predicts contents, write counts, status and run length.
// Stimulus is a linear directed sequence followed by randomized runs.
module tb_vector_dispatch_engine;

    logic        clk;
    logic        rst_n;
    logic [1:0]  address_control;
    logic [31:0] data_in_control;
    logic        write_control;
    logic        read_control;

    logic [31:0] data_out1, dout1, din1;
    logic [15:0] addr1;
    logic        wren1, irq1;
    logic [31:0] data_out3, dout3, din3;
    logic [15:0] addr3;
    logic        wren3, irq3;

    vector_dispatch_engine #(.WIDTH(32), .ADDR_WIDTH(16), .MEM_LATENCY(1), .MAX_SIZE(1024)) u1 (
        .clk(clk), .reset_sink_reset_n(rst_n), .address_control(address_control),
        .data_in_control(data_in_control), .write_control(write_control), .read_control(read_control),
        .data_out_control(data_out1), .mem_address(addr1), .mem_data_out(dout1),
        .mem_data_in(din1), .mem_wren(wren1), .interrupt_start(irq1));

    vector_dispatch_engine #(.WIDTH(32), .ADDR_WIDTH(16), .MEM_LATENCY(3), .MAX_SIZE(1024)) u3 (
        .clk(clk), .reset_sink_reset_n(rst_n), .address_control(address_control),
        .data_in_control(data_in_control), .write_control(write_control), .read_control(read_control),
        .data_out_control(data_out3), .mem_address(addr3), .mem_data_out(dout3),
        .mem_data_in(din3), .mem_wren(wren3), .interrupt_start(irq3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models with 1- and 3-cycle read latency, plus a bench load port.
    bit   [31:0] ram1 [0:65535];
    bit   [31:0] ram3 [0:65535];
    bit   [31:0] ref_ram [0:65535];
    logic [15:0] ap1;
    logic [15:0] ap3 [0:2];
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [31:0] ld_dat;
    int          wc1, wc3;

    initial begin
        wc1 = 0;
        wc3 = 0;
    end

    always @(posedge clk) begin
        ap1    <= addr1;
        ap3[0] <= addr3;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
        if (wren1) begin
            ram1[addr1] <= dout1;
            wc1 <= wc1 + 1;
        end
        if (wren3) begin
            ram3[addr3] <= dout3;
            wc3 <= wc3 + 1;
        end
        if (ld_en) begin
            ram1[ld_addr] <= ld_dat;
            ram3[ld_addr] <= ld_dat;
        end
    end
    assign din1 = ram1[ap1];
    assign din3 = ram3[ap3[2]];

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        ref_ram[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        write_control = 1'b1; address_control = a; data_in_control = d;
        @(negedge clk);
        write_control = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d1, output logic [31:0] d3);
        @(negedge clk);
        read_control = 1'b1; address_control = a;
        @(negedge clk);
        read_control = 1'b0;
        d1 = data_out1;
        d3 = data_out3;
    endtask

    function automatic logic [31:0] fop(input logic [1:0] op, input logic [31:0] x, input logic [31:0] s);
        logic [63:0] wide;
        case (op)
            2'd0: begin wide = 64'(x) + 64'(s); return wide[31:0]; end
            2'd1: begin wide = 64'(x) * 64'(s); return wide[31:0]; end
            2'd2: return x ^ s;
            default: return (x > s) ? x : s;
        endcase
    endfunction

    // Descriptor-level model: updates ref_ram, returns element count written and error flag.
    task automatic model(input logic [1:0] op, input logic [31:0] s, input logic [15:0] base,
                         output int nwr, output bit err);
        logic [31:0] size;
        logic [15:0] ptr, a;
        size = ref_ram[base];
        a    = base + 16'd1;
        ptr  = ref_ram[a][15:0];
        err  = (size > 32'd1024);
        nwr  = (err || size == 0) ? 0 : int'(size);
        for (int i = 0; i < nwr; i++) begin
            a = ptr + 16'(i);
            ref_ram[a] = fop(op, ref_ram[a], s);
        end
    endtask

    function automatic int run_len(input int lat, input int n);
        return 2 * (lat + 1) + n * (lat + 2) + 1;
    endfunction

    task automatic ram_cmp(input string tag);
        int m1, m3;
        m1 = 0; m3 = 0;
        for (int i = 0; i < 65536; i++) begin
            if (ram1[i] !== ref_ram[i]) m1++;
            if (ram3[i] !== ref_ram[i]) m3++;
        end
        chk({tag, "_ram_lat1"}, 64'(m1), 64'd0);
        chk({tag, "_ram_lat3"}, 64'(m3), 64'd0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_addr1"}, 64'(addr1), 64'd0);
        chk({tag, "_wren1"}, 64'(wren1), 64'd0);
        chk({tag, "_dout1"}, 64'(dout1), 64'd0);
        chk({tag, "_irq1"},  64'(irq1),  64'd0);
        chk({tag, "_rd1"},   64'(data_out1), 64'd0);
        chk({tag, "_addr3"}, 64'(addr3), 64'd0);
        chk({tag, "_wren3"}, 64'(wren3), 64'd0);
        chk({tag, "_dout3"}, 64'(dout3), 64'd0);
        chk({tag, "_irq3"},  64'(irq3),  64'd0);
        chk({tag, "_rd3"},   64'(data_out3), 64'd0);
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] s,
                             input logic [15:0] base, input bit poke_busy);
        int          nwr, c, l1, l3, w1s, w3s;
        bit          err;
        logic [31:0] r1, r3;
        wr_reg(2'd3, s);
        wr_reg(2'd2, {16'h0, base});
        model(op, s, base, nwr, err);
        w1s = wc1;
        w3s = wc3;
        wr_reg(2'd0, {28'h0, op, 2'b11});
        c = 1; l1 = -1; l3 = -1;
        while ((l1 < 0 || l3 < 0) && c < 8000) begin
            if (l1 < 0 && irq1) l1 = c - 1;
            if (l3 < 0 && irq3) l3 = c - 1;
            if (poke_busy) begin
                if (c == 3) begin
                    write_control = 1'b1; address_control = 2'd0;
                    data_in_control = {28'h0, ~op, 2'b11};
                end
                if (c == 4) write_control = 1'b0;
                if (c == 6) begin read_control = 1'b1; address_control = 2'd1; end
                if (c == 7) begin
                    read_control = 1'b0;
                    chk({tag, "_busy1"}, 64'(data_out1[0]), 64'd1);
                    chk({tag, "_busy3"}, 64'(data_out3[0]), 64'd1);
                end
            end
            @(negedge clk);
            c++;
        end
        chk({tag, "_len_lat1"}, 64'(l1), 64'(run_len(1, nwr)));
        chk({tag, "_len_lat3"}, 64'(l3), 64'(run_len(3, nwr)));
        chk({tag, "_wren_cnt1"}, 64'(wc1 - w1s), 64'(nwr));
        chk({tag, "_wren_cnt3"}, 64'(wc3 - w3s), 64'(nwr));
        ram_cmp(tag);
        rd_reg(2'd1, r1, r3);
        chk({tag, "_status1"}, 64'(r1), err ? 64'd6 : 64'd2);
        chk({tag, "_status3"}, 64'(r3), err ? 64'd6 : 64'd2);
        wr_reg(2'd1, 32'h6);
        chk({tag, "_irq_clr1"}, 64'(irq1), 64'd0);
        chk({tag, "_irq_clr3"}, 64'(irq3), 64'd0);
        rd_reg(2'd1, r1, r3);
        chk({tag, "_status_clr1"}, 64'(r1), 64'd0);
        chk({tag, "_status_clr3"}, 64'(r3), 64'd0);
    endtask

    initial begin
        logic [31:0] r1, r3;
        logic [15:0] rb, rp;
        int          rs;
        logic [1:0]  rop;
        logic [31:0] rsc;

        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        address_control = '0; data_in_control = '0;
        write_control = 1'b0; read_control = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs_zero("reset");
        rst_n = 1'b1;
        rd_reg(2'd0, r1, r3);
        chk("reset_ctrl1", 64'(r1), 64'd0);
        chk("reset_ctrl3", 64'(r3), 64'd0);
        rd_reg(2'd1, r1, r3);
        chk("reset_status1", 64'(r1), 64'd0);
        chk("reset_status3", 64'(r3), 64'd0);

        // ADD over a four-element vector.
        poke(16'd0, 32'd4); poke(16'd1, 32'd2);
        for (int i = 0; i < 4; i++) poke(16'(2 + i), 32'(3 + i));
        poke(16'd6, 32'h77);
        run_check("add", 2'd0, 32'd1, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("add_elem1", 64'(ram1[2 + i]), 64'(4 + i));
            chk("add_elem3", 64'(ram3[2 + i]), 64'(4 + i));
        end
        chk("add_untouched", 64'(ram1[6]), 64'h77);

        // MUL overflow and unsigned MAX.
        poke(16'h10, 32'd1); poke(16'h11, 32'h20); poke(16'h20, 32'h8000_0001);
        run_check("mul", 2'd1, 32'd2, 16'h10, 1'b0);
        chk("mul_elem", 64'(ram3[16'h20]), 64'h2);
        poke(16'h10, 32'd2); poke(16'h11, 32'h30); poke(16'h30, 32'd1); poke(16'h31, 32'd9);
        run_check("max", 2'd3, 32'd5, 16'h10, 1'b0);
        chk("max_elem0", 64'(ram1[16'h30]), 64'd5);
        chk("max_elem1", 64'(ram1[16'h31]), 64'd9);

        // Size boundaries: empty, one past the limit, exactly at the limit.
        poke(16'h10, 32'd0); poke(16'h11, 32'h40); poke(16'h40, 32'h1234);
        run_check("size0", 2'd0, 32'd7, 16'h10, 1'b0);
        chk("size0_untouched", 64'(ram1[16'h40]), 64'h1234);
        poke(16'h10, 32'd1025);
        run_check("oversize", 2'd0, 32'd7, 16'h10, 1'b0);
        chk("oversize_untouched", 64'(ram3[16'h40]), 64'h1234);
        poke(16'h10, 32'd1024); poke(16'h11, 32'h8000);
        run_check("maxsize", 2'd0, 32'd1, 16'h10, 1'b0);

        // Pointer wrap with an ignored start (different op) issued mid-run.
        poke(16'h10, 32'd3); poke(16'h11, 32'hFFFE);
        poke(16'hFFFE, 32'd10); poke(16'hFFFF, 32'd20); poke(16'h0000, 32'd30);
        run_check("wrap", 2'd2, 32'hF0, 16'h10, 1'b1);
        chk("wrap_fffe", 64'(ram1[16'hFFFE]), 64'(32'd10 ^ 32'hF0));
        chk("wrap_ffff", 64'(ram3[16'hFFFF]), 64'(32'd20 ^ 32'hF0));
        chk("wrap_0000", 64'(ram1[16'h0000]), 64'(32'd30 ^ 32'hF0));
        rd_reg(2'd0, r1, r3);
        chk("ctrl_updated_while_busy", 64'(r1), 64'h6);

        // Descriptor at the top of memory: BASE+1 wraps to 0.
        poke(16'hFFFF, 32'd2); poke(16'h0000, 32'h100); poke(16'h100, 32'd5); poke(16'h101, 32'd6);
        run_check("basewrap", 2'd0, 32'd3, 16'hFFFF, 1'b0);
        chk("basewrap_elem", 64'(ram1[16'h100]), 64'd8);

        // Reset pulse while the latency-1 instance waits on element 2.
        poke(16'h10, 32'd6); poke(16'h11, 32'h200);
        for (int i = 0; i < 6; i++) poke(16'(16'h200 + i), 32'(100 + i));
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd2, 32'h10);
        wr_reg(2'd0, 32'h3);
        repeat (11) @(negedge clk);
        chk("pre_reset_addr1", 64'(addr1), 64'h202);
        rst_n = 1'b0;
        #1;
        outs_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_el1_written", 64'(ram1[16'h201]), 64'd102);
        chk("reset_el2_untouched", 64'(ram1[16'h202]), 64'd102);
        chk("reset_lat3_untouched", 64'(ram3[16'h200]), 64'd100);
        poke(16'h200, 32'd100); poke(16'h201, 32'd101);
        rd_reg(2'd1, r1, r3);
        chk("post_reset_status1", 64'(r1), 64'd0);
        chk("post_reset_status3", 64'(r3), 64'd0);
        poke(16'h18, 32'd2); poke(16'h19, 32'h300);
        poke(16'h300, $urandom); poke(16'h301, $urandom);
        run_check("after_reset", 2'd0, 32'd1, 16'h18, 1'b0);

        // Randomized runs.
        for (int k = 0; k < 6; k++) begin
            rb  = 16'h2000 + 16'(k * 4);
            rp  = 16'h4000 + 16'(k * 16);
            rs  = int'($urandom_range(6, 1));
            poke(rb, 32'(rs));
            poke(rb + 16'd1, {16'h0, rp});
            for (int i = 0; i < rs; i++) poke(rp + 16'(i), $urandom);
            rop = 2'($urandom_range(3, 0));
            rsc = $urandom;
            run_check("rand", rop, rsc, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
